seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Inverse of the hex-to-7-segment path.
- Passively samples a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and recovers the displayed hex value.
- Used on-chip as a display monitor and self-check: the processor or bench reads back what the display shows and compares it against the value written.
- Single clock domain, same as the display scanner that drives the bus.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines); hex_out is 4*NUM_DIGITS bits.
- STABLE_CYCLES, 4, consecutive equal registered samples required before a digit is accepted (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines, active-low (0 = lit), bit order g..a as bits 6..0.
- an_in  input  NUM_DIGITS  digit enables, active-low; a valid sample has exactly one bit low, and bit i selects nibble i.
- hex_out  output  4*NUM_DIGITS  last complete frame; nibble i = digit i.
- frame_valid  output  1  one-cycle pulse when hex_out updates.
- frame_err  output  1  qualified by frame_valid; 1 if any digit in the frame had an unrecognised pattern.

Behaviour:
- Reset (rst=1 at a clock edge): all of the following clear to 0: hex_out, frame_valid, frame_err, input sample registers, stable counter, capture mask, per-digit error bits and the digit staging register.
- Reset mid-frame discards the partial frame entirely.

Input sampling:
- Input sampling: an_q/seg_q register an_in/seg_in every cycle (1-cycle latency).
- One-hot check: a sample is valid when an_q has exactly one 0 bit. Zero or multiple low bits means idle or ghosting.

Stable counter (cnt, saturating at STABLE_CYCLES):
- Invalid sample -> cnt=0.
- Valid sample differing from the previous registered pair -> cnt=1.
- Valid sample equal to the previous pair -> cnt=min(cnt+1, STABLE_CYCLES).

Capture:
- A capture fires exactly once per stable run, at the edge where cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES. With STABLE_CYCLES=1, it fires on the first valid sample of each run.
- No re-capture occurs until the pair changes or becomes invalid.
- A pair first presented on the inputs in cycle 0 is captured at the end of cycle STABLE_CYCLES.

Decode (on capture, for digit index k = position of the low an_q bit):
- The seg_q pattern is decoded with the 16-entry active-low table. Examples: 0=1000000, 1=1111001, 8=0000000, 9=0011000, A=0001000, b=0000011, F=0001110.
- Match: stage[k] = nibble and err[k] = 0.
- No match (including blank 1111111): stage[k] = 4'h0 and err[k] = 1.
- In both cases, mask[k] = 1.

Recapture before frame completion:
- Overwrites stage[k] and err[k]; the mask is unchanged.

Frame completion:
- When the capture sets the last 0 bit of mask, the next edge does all of the following:
  - hex_out <= stage (including the nibble just captured);
  - frame_valid <= 1;
  - frame_err <= OR of err (including the digit just captured);
  - mask and err clear.
- frame_valid is 1 for exactly one cycle. hex_out holds its value until the next frame.
- A capture in the same cycle as frame completion starts the new frame: its mask and err bits are set after the clear.

Boundary rules:
- An idle bus (no valid samples) never produces frame_valid.
- Digits may arrive in any order or repeat; only completeness of the mask matters.

Decomposition:
- Shared package/include seg7_codes holds the 16 active-low segment constants SEG7_0..SEG7_F and SEG7_BLANK, shared with the existing hex-to-7-segment decoder so both directions use one table.
- One sub-module, seg7_to_hex: purely combinational.
  - Inputs: 7-bit pattern.
  - Outputs: 4-bit nibble and a match flag.
- The top holds sampling, counter, mask and frame logic.

Test Plan:
- Scan 1 (STABLE_CYCLES=4, NUM_DIGITS=4): hold each of digits 0..3 for 8 cycles with patterns for 1,2,3,4 (an_in=1110,1101,1011,0111) -> one frame_valid pulse, hex_out=16'h4321, frame_err=0, and the pulse arrives 1 cycle after digit 3 captures.
- Scan 2: as scan 1, but digit 3 is held only 3 cycles before switching back to digit 0 -> digit 3 is not captured and no frame_valid occurs until digit 3 is later held for ≥4 cycles.
- Scan 3: digit 2 shows 1111111 (blank), others show A,b,F -> frame_valid with frame_err=1, and the digit-2 nibble is 0.
- Scan 4: an_in=1100 or 1111 held for 20 cycles between digits -> no capture and cnt stays 0; a normal scan afterward produces the correct frame.
- Scan 5: digit 1 is shown as 5 and then recaptured as 9 before the frame completes -> hex_out nibble 1 = 9, and exactly one frame_valid pulse.
- Scan 6: rst asserted after 3 of 4 digits are captured -> all outputs are 0; digits 0..2 must be recaptured before the next frame_valid, and a lone digit-3 capture alone produces no frame.

Source files
------------

// File: rtl/seg7_capture_pkg.sv
// seg7_codes: active-low 7-segment patterns (bit order g..a = bits 6..0),
// shared by the hex-to-7-segment encoder and the seg7_capture readback path
// so both directions use exactly one table.
package seg7_codes;

    localparam logic [6:0] SEG7_0     = 7'b1000000;
    localparam logic [6:0] SEG7_1     = 7'b1111001;
    localparam logic [6:0] SEG7_2     = 7'b0100100;
    localparam logic [6:0] SEG7_3     = 7'b0110000;
    localparam logic [6:0] SEG7_4     = 7'b0011001;
    localparam logic [6:0] SEG7_5     = 7'b0010010;
    localparam logic [6:0] SEG7_6     = 7'b0000010;
    localparam logic [6:0] SEG7_7     = 7'b1111000;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0011000;
    localparam logic [6:0] SEG7_A     = 7'b0001000;
    localparam logic [6:0] SEG7_B     = 7'b0000011;
    localparam logic [6:0] SEG7_C     = 7'b1000110;
    localparam logic [6:0] SEG7_D     = 7'b0100001;
    localparam logic [6:0] SEG7_E     = 7'b0000110;
    localparam logic [6:0] SEG7_F     = 7'b0001110;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: display bus being monitored plus the recovered frame.
//   seg_in      - segment lines, active-low, g..a = bits 6..0
//   an_in       - digit enables, active-low, one low bit per valid sample
//   hex_out     - last complete frame, nibble i = digit i
//   frame_valid - one-cycle pulse when hex_out updates
//   frame_err   - frame contained an unrecognised pattern (with frame_valid)
// master: display side / checker; slave: seg7_capture.
interface seg7_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic                    frame_valid;
    logic                    frame_err;

    modport master (
        output seg_in, an_in,
        input  hex_out, frame_valid, frame_err
    );

    modport slave (
        input  seg_in, an_in,
        output hex_out, frame_valid, frame_err
    );
endinterface

// File: rtl/seg7_capture_to_hex.sv
// seg7_to_hex: combinational reverse lookup of an active-low segment pattern.
//   seg    - 7-bit pattern (g..a)
//   nibble - decoded hex value, 0 when no entry matches
//   match  - 1 when seg is one of the 16 hex glyphs
module seg7_to_hex
    import seg7_codes::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       match
);

    always_comb begin
        nibble = 4'h0;
        match  = 1'b1;
        case (seg)
            SEG7_0: nibble = 4'h0;
            SEG7_1: nibble = 4'h1;
            SEG7_2: nibble = 4'h2;
            SEG7_3: nibble = 4'h3;
            SEG7_4: nibble = 4'h4;
            SEG7_5: nibble = 4'h5;
            SEG7_6: nibble = 4'h6;
            SEG7_7: nibble = 4'h7;
            SEG7_8: nibble = 4'h8;
            SEG7_9: nibble = 4'h9;
            SEG7_A: nibble = 4'hA;
            SEG7_B: nibble = 4'hB;
            SEG7_C: nibble = 4'hC;
            SEG7_D: nibble = 4'hD;
            SEG7_E: nibble = 4'hE;
            SEG7_F: nibble = 4'hF;
            default: match = 1'b0;  // includes SEG7_BLANK
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: passive monitor of a multiplexed active-low 7-segment bus.
// Registers the bus, waits for STABLE_CYCLES equal valid samples, decodes the
// digit into a staging register and, once every digit has been seen, publishes
// the whole frame on hex_out with a one-cycle frame_valid pulse.
//   clk, rst - clock, synchronous active-high reset
//   bus      - seg7_capture_if slave (seg_in/an_in in, hex_out/frame_* out)
module seg7_capture
    import seg7_codes::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg7_capture_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]       an_q, an_d, an_prev_q, an_prev_d;
    logic [6:0]                  seg_q, seg_d, seg_prev_q, seg_prev_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d, err_q, err_d;
    logic [NUM_DIGITS-1:0][3:0]  stage_q, stage_d;
    logic [4*NUM_DIGITS-1:0]     hex_q, hex_d;
    logic                        fv_q, fv_d, fe_q, fe_d;

    logic [NUM_DIGITS-1:0] sel;
    logic                  valid, diff, capture, mask_full;
    logic [3:0]            dec_nib;
    logic                  dec_match;

    seg7_to_hex u_dec (
        .seg    (seg_q),
        .nibble (dec_nib),
        .match  (dec_match)
    );

    always_comb begin
        an_d       = bus.an_in;
        seg_d      = bus.seg_in;
        an_prev_d  = an_q;
        seg_prev_d = seg_q;

        // Valid sample: exactly one anode low, i.e. ~an_q is one-hot.
        sel   = ~an_q;
        valid = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        diff  = (an_q != an_prev_q) || (seg_q != seg_prev_q);

        if (!valid)               cnt_d = '0;
        else if (diff)            cnt_d = CW'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        else                      cnt_d = cnt_q;

        // Fires only on the step into saturation, so a held digit is taken once.
        // A new run with STABLE_CYCLES==1 saturates immediately.
        capture = valid && (diff ? (STABLE_CYCLES == 1) : (cnt_q == CNT_PRE));

        // Mask filled on the previous edge: publish this edge and start over.
        mask_full = &mask_q;
        hex_d     = mask_full ? stage_q : hex_q;
        fv_d      = mask_full;
        fe_d      = mask_full ? (|err_q) : fe_q;
        mask_d    = mask_full ? '0 : mask_q;
        err_d     = mask_full ? '0 : err_q;
        stage_d   = stage_q;

        // Applied after the clear so a same-edge capture opens the next frame.
        if (capture) begin
            mask_d = mask_d | sel;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    stage_d[i] = dec_match ? dec_nib : 4'h0;
                    err_d[i]   = !dec_match;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q       <= '0;
            seg_q      <= '0;
            an_prev_q  <= '0;
            seg_prev_q <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            err_q      <= '0;
            stage_q    <= '0;
            hex_q      <= '0;
            fv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            an_q       <= an_d;
            seg_q      <= seg_d;
            an_prev_q  <= an_prev_d;
            seg_prev_q <= seg_prev_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            stage_q    <= stage_d;
            hex_q      <= hex_d;
            fv_q       <= fv_d;
            fe_q       <= fe_d;
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       err;
    } vec_t;

    vec_t vt[17];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor, sampled on the falling edge.
    int          pulses    = 0;
    int          pulse_cyc = -1;
    logic [15:0] last_hex  = '0;
    logic        last_err  = 1'b0;
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
            last_hex  = bus.hex_out;
            last_err  = bus.frame_err;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dig(input int d, input int v, input int n);
        hold(an_of(d), vt[v].seg, n);
    endtask

    int p0;
    int c3;
    int pos;
    logic [15:0] exp_hex;

    initial begin
        vt[0]  = '{7'b1000000, 4'h0, 1'b0};
        vt[1]  = '{7'b1111001, 4'h1, 1'b0};
        vt[2]  = '{7'b0100100, 4'h2, 1'b0};
        vt[3]  = '{7'b0110000, 4'h3, 1'b0};
        vt[4]  = '{7'b0011001, 4'h4, 1'b0};
        vt[5]  = '{7'b0010010, 4'h5, 1'b0};
        vt[6]  = '{7'b0000010, 4'h6, 1'b0};
        vt[7]  = '{7'b1111000, 4'h7, 1'b0};
        vt[8]  = '{7'b0000000, 4'h8, 1'b0};
        vt[9]  = '{7'b0011000, 4'h9, 1'b0};
        vt[10] = '{7'b0001000, 4'hA, 1'b0};
        vt[11] = '{7'b0000011, 4'hB, 1'b0};
        vt[12] = '{7'b1000110, 4'hC, 1'b0};
        vt[13] = '{7'b0100001, 4'hD, 1'b0};
        vt[14] = '{7'b0000110, 4'hE, 1'b0};
        vt[15] = '{7'b0001110, 4'hF, 1'b0};
        vt[16] = '{7'b1111111, 4'h0, 1'b1};  // blank: no match

        rst        = 1'b1;
        bus.an_in  = 4'hF;
        bus.seg_in = 7'h7F;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_hex", bus.hex_out, 16'h0);
        chk("reset_fv", bus.frame_valid, 1'b0);
        chk("reset_fe", bus.frame_err, 1'b0);
        rst = 1'b0;

        // Decode table: each entry shown on one digit, 0 on the others.
        for (int i = 0; i < 17; i++) begin
            pos = i % 4;
            p0  = pulses;
            for (int d = 0; d < 4; d++)
                hold(an_of(d), (d == pos) ? vt[i].seg : vt[0].seg, 8);
            exp_hex = 16'(vt[i].nib) << (4 * pos);
            chk($sformatf("tbl%0d_pulses", i), pulses - p0, 1);
            chk($sformatf("tbl%0d_hex", i), last_hex, exp_hex);
            chk($sformatf("tbl%0d_err", i), last_err, vt[i].err);
        end

        // Scan 1: 1,2,3,4 -> 4321, pulse 1 cycle after digit 3 capture.
        p0 = pulses;
        dig(0, 1, 8); dig(1, 2, 8); dig(2, 3, 8);
        c3 = cyc;
        dig(3, 4, 8);
        chk("s1_pulses", pulses - p0, 1);
        chk("s1_hex", last_hex, 16'h4321);
        chk("s1_err", last_err, 1'b0);
        chk("s1_pulse_cyc", pulse_cyc, c3 + SC + 2);
        chk("s1_fv_low_after", bus.frame_valid, 1'b0);
        chk("s1_hex_hold", bus.hex_out, 16'h4321);

        // Scan 2: digit 3 held only 3 cycles -> no frame until held longer.
        p0 = pulses;
        dig(0, 1, 8); dig(1, 2, 8); dig(2, 3, 8); dig(3, 4, 3); dig(0, 1, 8);
        chk("s2_no_pulse", pulses - p0, 0);
        dig(3, 4, 8);
        chk("s2_pulses", pulses - p0, 1);
        chk("s2_hex", last_hex, 16'h4321);

        // Scan 3: blank on digit 2.
        p0 = pulses;
        dig(0, 10, 8); dig(1, 11, 8); dig(2, 16, 8); dig(3, 15, 8);
        chk("s3_pulses", pulses - p0, 1);
        chk("s3_hex", last_hex, 16'hF0BA);
        chk("s3_err", last_err, 1'b1);

        // Scan 4: ghosting / idle gaps between digits.
        p0 = pulses;
        dig(0, 7, 8);  hold(4'b1100, vt[8].seg, 20);
        dig(1, 8, 8);  hold(4'b1111, vt[8].seg, 20);
        dig(2, 12, 8); hold(4'b1100, vt[3].seg, 20);
        chk("s4_no_pulse", pulses - p0, 0);
        dig(3, 14, 8);
        chk("s4_pulses", pulses - p0, 1);
        chk("s4_hex", last_hex, 16'hEC87);
        chk("s4_err", last_err, 1'b0);

        // Scan 5: digit 1 recaptured 5 -> 9 within the frame.
        p0 = pulses;
        dig(0, 1, 8); dig(1, 5, 8); dig(2, 3, 8); dig(1, 9, 8);
        chk("s5_no_early", pulses - p0, 0);
        dig(3, 4, 8);
        chk("s5_pulses", pulses - p0, 1);
        chk("s5_hex", last_hex, 16'h4391);

        // Scan 6: reset after three digits discards the partial frame.
        p0 = pulses;
        dig(0, 6, 8); dig(1, 13, 8); dig(2, 2, 8);
        rst = 1'b1;
        hold(4'hF, 7'h7F, 2);
        chk("s6_rst_hex", bus.hex_out, 16'h0);
        chk("s6_rst_fv", bus.frame_valid, 1'b0);
        chk("s6_rst_fe", bus.frame_err, 1'b0);
        rst = 1'b0;
        dig(3, 4, 8); hold(4'hF, 7'h7F, 4);
        chk("s6_lone_d3", pulses - p0, 0);
        dig(0, 6, 8); dig(1, 13, 8);
        chk("s6_partial", pulses - p0, 0);
        dig(2, 2, 8);
        chk("s6_pulses", pulses - p0, 1);
        chk("s6_hex", last_hex, 16'h42D6);
        chk("s6_err", last_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
